awgn_sched_ctlr: RTL

//  Sequencer and sample scheduler for the Box-Muller AWGN core (taus/concat/log/sin_cos/sqrt/mul_cal).

---
 rtl/awgn_sched_pkg.sv | 14 +
 rtl/awgn_sched_ctlr_if.sv | 15 +
 rtl/awgn_pair_fifo.sv | 55 +++++
 rtl/awgn_sched_ctlr.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/awgn_sched_pkg.sv
// Shared types and constants for the AWGN core sequencer / sample scheduler.
package awgn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } state_t;

  localparam int unsigned SEED_W    = 32;
  localparam int unsigned NUM_SEEDS = 6;
  localparam int unsigned SAMPLE_W  = 32;

endpackage

// File: rtl/awgn_sched_ctlr_if.sv
// Consumer-side bus: per-consumer request, one-hot grant and granted sample pair.
interface awgn_sched_ctlr_if
  import awgn_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt;
  logic [SAMPLE_W-1:0] sample_out;

  modport master (input req, output gnt, output sample_out);
  modport slave  (output req, input gnt, input sample_out);

endinterface

// File: rtl/awgn_pair_fifo.sv
// Synchronous FIFO for {awgn_1,awgn_0} sample pairs; head is presented combinationally.
module awgn_pair_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];
  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/awgn_sched_ctlr.sv
// Box-Muller AWGN core sequencer: seed bank, IDLE/WARMUP/RUN control, sample-pair FIFO
// and round-robin hand-out to NUM_REQ consumers.
// Optional build macro AWGN_DROP_CNT_EN adds drop_cnt (pairs dropped on a full FIFO).
module awgn_sched_ctlr
  import awgn_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned FIFO_DEP = 8,
  parameter int unsigned PIPE_LAT = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          seed_we,
  input  logic [2:0]                    seed_idx,
  input  logic [SEED_W-1:0]             seed_wdata,
  output logic                          core_reset,
  output logic [NUM_SEEDS*SEED_W-1:0]   urng_seed,
  input  logic [15:0]                   awgn_in_0,
  input  logic [15:0]                   awgn_in_1,
  awgn_sched_ctlr_if.master             cons,
  output logic                          busy,
  output logic [$clog2(FIFO_DEP):0]     fifo_level
`ifdef AWGN_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned PW = $clog2(NUM_REQ);

  state_t                       state;
  state_t                       state_nxt;
  logic [CW-1:0]                warm_cnt;
  logic [NUM_SEEDS*SEED_W-1:0]  seed_bank;
  logic [PW-1:0]                rr_ptr;
  logic [PW-1:0]                gnt_idx;
  logic                         found;
  logic                         go;
  logic                         halt;
  logic                         warm_done;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [SAMPLE_W-1:0]          fifo_dout;

  assign go        = start && !stop && (state == ST_IDLE);
  assign halt      = stop && (state != ST_IDLE);
  assign warm_done = (warm_cnt == CW'(PIPE_LAT - 1));
  assign fifo_pop  = !fifo_empty && (|cons.req) && !halt;
  assign fifo_push = (state == ST_RUN) && !halt && (!fifo_full || fifo_pop);
  assign urng_seed = seed_bank;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; stop outranks start
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (go) state_nxt = ST_WARMUP;
      ST_WARMUP: if (halt) state_nxt = ST_IDLE;
                 else if (warm_done) state_nxt = ST_RUN;
      ST_RUN:    if (halt) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Core control outputs from state
  always_comb begin
    core_reset = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
  end

  // Warm-up counter: counts only in WARMUP, parks at zero elsewhere
  always_ff @(posedge clk) begin
    if (reset) warm_cnt <= '0;
    else if ((state == ST_WARMUP) && !halt && !warm_done) warm_cnt <= warm_cnt + 1'b1;
    else warm_cnt <= '0;
  end

  // Seed bank, writable only while the core is held in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_bank <= '0;
    end else if (seed_we && (state == ST_IDLE)) begin
      for (int unsigned i = 0; i < NUM_SEEDS; i++)
        if (seed_idx == 3'(i)) seed_bank[i*SEED_W +: SEED_W] <= seed_wdata;
    end
  end

  // Round-robin pick: first requester at or above rr_ptr, else first below it
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (!found && (i >= 32'(rr_ptr)) && cons.req[i]) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (!found && (i < 32'(rr_ptr)) && cons.req[i]) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
  end

  // Registered grant, sample hand-out and pointer advance
  always_ff @(posedge clk) begin
    if (reset) begin
      cons.gnt        <= '0;
      cons.sample_out <= '0;
      rr_ptr          <= '0;
    end else begin
      cons.gnt <= '0;
      if (fifo_pop) begin
        cons.gnt        <= NUM_REQ'(1) << gnt_idx;
        cons.sample_out <= fifo_dout;
        rr_ptr          <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef AWGN_DROP_CNT_EN
  logic drop;
  assign drop = (state == ST_RUN) && !halt && fifo_full && !fifo_pop;

  // Saturating count of pairs lost to a full FIFO; restarts with each run
  always_ff @(posedge clk) begin
    if (reset || go) drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  awgn_pair_fifo #(
    .DEPTH (FIFO_DEP),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (halt),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({awgn_in_1, awgn_in_0}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule
